// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WRITE,
    RUN
  } loader_state_t;

  localparam int CHECKSUM_WIDTH = 16;

endpackage

// File: rtl/program_loader.sv
// Copies PROG_LEN words from a 1-cycle-latency ROM into the CPU instruction
// memory (3 cycles per word), holding the CPU until the image is in place.
module program_loader
  import loader_pkg::*;
#(
  parameter int INDEX_WIDTH = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int BASE_INDEX  = 10,
  parameter int PROG_LEN    = 13,
  parameter int AUTO_START  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [INDEX_WIDTH-1:0]    rom_addr,
  input  logic [INSTR_WIDTH-1:0]    rom_data,
  output logic                      cpu_write,
  output logic [INDEX_WIDTH-1:0]    cpu_write_index,
  output logic [INSTR_WIDTH-1:0]    cpu_write_instruction,
  output logic                      cpu_run,
  output logic                      busy,
  output logic                      done,
  output logic [CHECKSUM_WIDTH-1:0] checksum
);

  // One extra bit so the count can reach PROG_LEN itself.
  localparam int COUNT_WIDTH = INDEX_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT =
    (PROG_LEN == 0) ? '0 : COUNT_WIDTH'(PROG_LEN - 1);
  localparam logic [INDEX_WIDTH-1:0] BASE = INDEX_WIDTH'(BASE_INDEX);

  if (PROG_LEN < 0 || BASE_INDEX < 0 ||
      BASE_INDEX + PROG_LEN > (1 << INDEX_WIDTH)) begin : g_bad_image_range
    $fatal(1, "program_loader: BASE_INDEX+PROG_LEN exceeds the instruction index range");
  end

  loader_state_t          state;
  logic [COUNT_WIDTH-1:0] count;
  logic                   armed;

  // NOTE: every register, including the latched instruction word, is cleared by the
  // asynchronous reset so an aborted load leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      count                 <= '0;
      armed                 <= (AUTO_START != 0);
      rom_addr              <= '0;
      cpu_write_index       <= BASE;
      cpu_write_instruction <= '0;
      checksum              <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge value of count, rom_addr and checksum.
      armed <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (start || armed) begin
            count    <= '0;
            checksum <= '0;
            rom_addr <= '0;
            state    <= (PROG_LEN == 0) ? RUN : FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          cpu_write_instruction <= rom_data;
          cpu_write_index       <= BASE + count[INDEX_WIDTH-1:0];
          state                 <= WRITE;
        end
        WRITE: begin
          checksum <= checksum + CHECKSUM_WIDTH'(cpu_write_instruction);
          count    <= count + 1'b1;
          rom_addr <= rom_addr + 1'b1;
          state    <= (count == LAST_COUNT) ? RUN : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status strobes decode straight from the state register.
  assign cpu_write = (state == WRITE);
  assign busy      = (state == FETCH) || (state == LATCH) || (state == WRITE);
  assign cpu_run   = (state == RUN);
  assign done      = (state == RUN);

endmodule
